// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
// The controller side drives operands and start; the adder side returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop process the
// operands LSB-first, one bit per clock, under an IDLE/RUN/DONE controller.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    // Full-adder cell shared by every bit position.
    always_comb begin
        w_fa_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_fa_cout = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
    end

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_acc_single
            assign w_acc_next = w_fa_s;
        end else begin : g_acc_multi
            assign w_acc_next = {w_fa_s, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == RUN);
        bus.done = (r_state == DONE);
    end

    // Operand shifters and partial sum never leak out, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.start) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_acc  <= '0;
        end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_acc  <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
